// File: rtl/cic_comb_chain.sv
// Comb (differentiator) section of the multi-channel CIC decimator.
// NUM_STAGES pipelined comb stages with per-channel (4 channel) delay
// registers, followed by an arithmetic right shift and truncation to
// OUT_WIDTH on a valid/ready output.
// Optional feature macro: CIC_COMB_ROUND_EN (round half up before the
// shift, plus one extra output pipeline register).
module cic_comb_chain #(
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned OUT_WIDTH  = 32,
  parameter int unsigned NUM_STAGES = 5
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 clr_i,
  input  logic [5:0]           shift_i,
  input  logic [WIDTH-1:0]     data_i,
  input  logic [1:0]           ch_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic [OUT_WIDTH-1:0] data_o,
  output logic [1:0]           ch_o,
  output logic                 valid_o,
  input  logic                 ready_i
);

  localparam int unsigned MAX_SH = WIDTH - OUT_WIDTH;
  localparam int unsigned LAST   = NUM_STAGES - 1;
  localparam int unsigned NCH    = 4;

  logic [WIDTH-1:0]      data_q [NUM_STAGES];
  logic [WIDTH-1:0]      data_d [NUM_STAGES];
  logic [1:0]            ch_q   [NUM_STAGES];
  logic [1:0]            ch_d   [NUM_STAGES];
  logic [NUM_STAGES-1:0] vld_q, vld_d;
  logic [WIDTH-1:0]      dly_q  [NUM_STAGES][NCH];
  logic [WIDTH-1:0]      dly_d  [NUM_STAGES][NCH];

  logic [WIDTH-1:0]      in_data [NUM_STAGES];
  logic [1:0]            in_ch   [NUM_STAGES];
  logic [NUM_STAGES-1:0] in_vld;

  logic                  adv;
  logic [6:0]            sh_amt;
  logic [WIDTH-1:0]      rnd_val;
  logic signed [WIDTH-1:0] shifted;
  logic [OUT_WIDTH-1:0]  scaled;

  // Effective shift, clamped so the result never shifts past the output width
  assign sh_amt = (32'(shift_i) > MAX_SH) ? 7'(MAX_SH) : 7'(shift_i);

`ifdef CIC_COMB_ROUND_EN
  // Round half up; the addition wraps in WIDTH bits (carry dropped)
  assign rnd_val = (sh_amt != 7'd0) ? (data_q[LAST] + (WIDTH'(1) << (sh_amt - 7'd1)))
                                    : data_q[LAST];
`else
  assign rnd_val = data_q[LAST];
`endif

  assign shifted = $signed(rnd_val) >>> sh_amt;
  assign scaled  = shifted[OUT_WIDTH-1:0];

  // Stage input mapping: stage 0 takes the port, later stages the previous stage
  always_comb begin
    in_data[0] = data_i;
    in_ch[0]   = ch_i;
    in_vld     = '0;
    in_vld[0]  = valid_i;
    for (int k = 1; k < NUM_STAGES; k++) begin
      in_data[k] = data_q[k-1];
      in_ch[k]   = ch_q[k-1];
      in_vld[k]  = vld_q[k-1];
    end
  end

  // Comb stage next state: y = x - x[-1] per channel, whole chain advances together
  always_comb begin
    data_d = data_q;
    ch_d   = ch_q;
    vld_d  = vld_q;
    dly_d  = dly_q;
    if (clr_i) begin
      vld_d = '0;
      for (int k = 0; k < NUM_STAGES; k++) begin
        for (int c = 0; c < NCH; c++) begin
          dly_d[k][c] = '0;
        end
      end
    end else if (adv) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        vld_d[k] = in_vld[k];
        if (in_vld[k]) begin
          data_d[k]              = in_data[k] - dly_q[k][in_ch[k]];
          ch_d[k]                = in_ch[k];
          dly_d[k][in_ch[k]]     = in_data[k];
        end
      end
    end
  end

  // Stage and delay-line registers
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      vld_q <= '0;
      for (int k = 0; k < NUM_STAGES; k++) begin
        data_q[k] <= '0;
        ch_q[k]   <= '0;
        for (int c = 0; c < NCH; c++) begin
          dly_q[k][c] <= '0;
        end
      end
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
      ch_q   <= ch_d;
      dly_q  <= dly_d;
    end
  end

`ifdef CIC_COMB_ROUND_EN
  logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
  logic [1:0]           out_ch_q, out_ch_d;
  logic                 out_vld_q, out_vld_d;

  assign adv = ~out_vld_q | ready_i;

  // Output register next state: captures the rounded, scaled last-stage value
  always_comb begin
    out_data_d = out_data_q;
    out_ch_d   = out_ch_q;
    out_vld_d  = out_vld_q;
    if (clr_i) begin
      out_vld_d = 1'b0;
    end else if (adv) begin
      out_vld_d = vld_q[LAST];
      if (vld_q[LAST]) begin
        out_data_d = scaled;
        out_ch_d   = ch_q[LAST];
      end
    end
  end

  // Output pipeline register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      out_data_q <= '0;
      out_ch_q   <= '0;
      out_vld_q  <= 1'b0;
    end else begin
      out_data_q <= out_data_d;
      out_ch_q   <= out_ch_d;
      out_vld_q  <= out_vld_d;
    end
  end

  assign data_o  = out_data_q;
  assign ch_o    = out_ch_q;
  assign valid_o = out_vld_q;
`else
  assign adv     = ~vld_q[LAST] | ready_i;
  assign data_o  = scaled;
  assign ch_o    = ch_q[LAST];
  assign valid_o = vld_q[LAST];
`endif

  assign ready_o = adv;

endmodule

// File: tb/tb_cic_comb_chain.sv
// Bench for cic_comb_chain (WIDTH=16, OUT_WIDTH=8, NUM_STAGES=2).
// Reference: per-channel N-th finite difference via binomial weights over
// the input history, plus integer scaling; also honours CIC_COMB_ROUND_EN.
module tb_cic_comb_chain;

  localparam int unsigned W   = 16;
  localparam int unsigned OW  = 8;
  localparam int          NS  = 2;
  localparam int          MAXSH = W - OW;
  localparam longint      MASK  = 64'hFFFF;
`ifdef CIC_COMB_ROUND_EN
  localparam int          LAT = NS + 1;
`else
  localparam int          LAT = NS;
`endif

  logic          clk_i, rstn_i, clr_i, valid_i, ready_i;
  logic [5:0]    shift_i;
  logic [W-1:0]  data_i;
  logic [1:0]    ch_i;
  logic          ready_o, valid_o;
  logic [OW-1:0] data_o;
  logic [1:0]    ch_o;

  cic_comb_chain #(.WIDTH(W), .OUT_WIDTH(OW), .NUM_STAGES(NS)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .clr_i(clr_i), .shift_i(shift_i),
    .data_i(data_i), .ch_i(ch_i), .valid_i(valid_i), .ready_o(ready_o),
    .data_o(data_o), .ch_o(ch_o), .valid_o(valid_o), .ready_i(ready_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_pass = 0;

  longint hist [4][NS+1];
  longint sb_raw [$];
  int     sb_ch  [$];
  longint dir_q  [$];

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic int binom(int n, int k);
    int r = 1;
    for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
    return r;
  endfunction

  function automatic longint exp_out(longint raw);
    int s;
    longint v;
    s = (int'(shift_i) > MAXSH) ? MAXSH : int'(shift_i);
    v = raw;
`ifdef CIC_COMB_ROUND_EN
    if (s > 0) v = (v + (longint'(1) << (s - 1))) & MASK;
`endif
    if (v >= 32768) v = v - 65536;
    v = v >>> s;
    return v & 255;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < 4; c++)
      for (int j = 0; j <= NS; j++) hist[c][j] = 0;
    sb_raw.delete();
    sb_ch.delete();
    dir_q.delete();
  endtask

  task automatic model_push(input longint x, input int c);
    longint acc = 0;
    for (int j = NS; j > 0; j--) hist[c][j] = hist[c][j-1];
    hist[c][0] = x;
    for (int j = 0; j <= NS; j++) begin
      if (j % 2 == 1) acc -= binom(NS, j) * hist[c][j];
      else            acc += binom(NS, j) * hist[c][j];
    end
    sb_raw.push_back(acc & MASK);
    sb_ch.push_back(c);
  endtask

  // One clock: evaluate handshakes on settled pre-edge values, then cross the edge
  task automatic tick();
    longint r;
    int c;
    #1;
    check("ready_o", longint'(ready_o), longint'(!valid_o || ready_i));
    if (valid_o && ready_i) begin
      if (sb_raw.size() == 0) check("spurious_out", 1, 0);
      else begin
        r = sb_raw.pop_front();
        c = sb_ch.pop_front();
        check("data_o", longint'(data_o), exp_out(r));
        check("ch_o", longint'(ch_o), longint'(c));
        if (dir_q.size() != 0) check("directed", longint'(data_o), dir_q.pop_front());
      end
    end
    if (clr_i) model_clear();
    else if (valid_i && ready_o) model_push(longint'(data_i), int'(ch_i));
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic feed(input longint x, input int c);
    valid_i = 1'b1;
    data_i  = W'(x);
    ch_i    = 2'(c);
    tick();
    valid_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    valid_i = 1'b0;
    clr_i   = 1'b0;
    ready_i = 1'b1;
    while (sb_raw.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    check("drain_empty", longint'(sb_raw.size()), 0);
    repeat (LAT + 2) tick();
  endtask

  task automatic pulse_clr();
    valid_i = 1'b0;
    clr_i   = 1'b1;
    tick();
    clr_i   = 1'b0;
  endtask

  longint ramp [5] = '{0, 1, 3, 6, 10};
  longint ramp_exp [5] = '{0, 1, 1, 1, 1};
  longint il_in [6] = '{5, 100, 5, 110, 5, 120};
  longint il_exp [6] = '{5, 100, 8'hFB, 8'hA6, 0, 0};

  initial begin
    logic [OW-1:0] hd;
    logic [1:0]    hc;
    int            n;

    rstn_i = 1'b0; clr_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    shift_i = '0; data_i = '0; ch_i = '0;
    model_clear();
    repeat (3) @(negedge clk_i);
    check("rst_valid_o", longint'(valid_o), 0);
    check("rst_data_o", longint'(data_o), 0);
    check("rst_ch_o", longint'(ch_o), 0);
    check("rst_ready_o", longint'(ready_o), 1);
    rstn_i = 1'b1;
    @(negedge clk_i);

    // Single-channel ramp: second difference 0,1,1,1,1
    for (int i = 0; i < 5; i++) begin
      dir_q.push_back(ramp_exp[i]);
      feed(ramp[i], 0);
    end
    drain();

    // Interleaved channels 0/1, independent histories
    pulse_clr();
    for (int i = 0; i < 6; i++) begin
      dir_q.push_back(il_exp[i]);
      feed(il_in[i], i % 2);
    end
    drain();

    // Backpressure: hold ready_i low with a valid output for 3 cycles
    for (int i = 0; i < 6; i++) feed(longint'($urandom_range(0, 65535)), int'($urandom_range(0, 3)));
    ready_i = 1'b0;
    valid_i = 1'b1;
    n = 0;
    while (!valid_o && n < 10) begin
      data_i = W'($urandom); ch_i = 2'($urandom); tick(); n++;
    end
    check("bp_valid", longint'(valid_o), 1);
    hd = data_o;
    hc = ch_o;
    for (int i = 0; i < 3; i++) begin
      data_i = W'($urandom); ch_i = 2'($urandom);
      tick();
      check("bp_ready_o", longint'(ready_o), 0);
      check("bp_data_hold", longint'(data_o), longint'(hd));
      check("bp_ch_hold", longint'(ch_o), longint'(hc));
    end
    valid_i = 1'b0;
    drain();

    // Clear forgets the 7,9 history on channel 2
    pulse_clr();
    feed(7, 2);
    feed(9, 2);
    pulse_clr();
    #1 check("clr_valid_drop", longint'(valid_o), 0);
    @(negedge clk_i);
    dir_q.push_back(4);
    feed(4, 2);
    drain();

    // Scaling and clamping of a fresh 0x1234 on channel 3
    pulse_clr();
    shift_i = 6'd4;
    dir_q.push_back(8'h23);
    feed(16'h1234, 3);
    drain();
    pulse_clr();
    shift_i = 6'd20;
    dir_q.push_back(8'h12);
    feed(16'h1234, 3);
    drain();

    // Rounding (or truncation) of 0x0018 >> 4, with latency measurement
    pulse_clr();
    shift_i = 6'd4;
`ifdef CIC_COMB_ROUND_EN
    dir_q.push_back(2);
`else
    dir_q.push_back(1);
`endif
    feed(16'h0018, 1);
    n = 1;
    while (!valid_o && n < 20) begin
      tick();
      n++;
    end
    check("latency", longint'(n), longint'(LAT));
    drain();

`ifndef CIC_COMB_ROUND_EN
    // Shift change applies immediately to the presented sample
    pulse_clr();
    ready_i = 1'b0;
    feed(16'h1234, 3);
    n = 0;
    while (!valid_o && n < 10) begin
      tick();
      n++;
    end
    shift_i = 6'd4;
    #1 check("live_shift4", longint'(data_o), 8'h23);
    shift_i = 6'd8;
    #1 check("live_shift8", longint'(data_o), 8'h12);
    drain();
`endif

    // Randomized traffic with stalls and occasional clears
    for (int blk = 0; blk < 6; blk++) begin
      shift_i = 6'($urandom_range(0, 12));
      for (int i = 0; i < 300; i++) begin
        valid_i = ($urandom_range(0, 3) != 0);
        data_i  = W'($urandom);
        ch_i    = 2'($urandom);
        ready_i = ($urandom_range(0, 3) != 0);
        clr_i   = ($urandom_range(0, 99) == 0);
        tick();
      end
      drain();
    end

    // Reset asserted mid-stream clears the output at once
    for (int i = 0; i < 3; i++) feed(longint'($urandom_range(0, 65535)), int'($urandom_range(0, 3)));
    rstn_i = 1'b0;
    #1 check("midrst_valid_o", longint'(valid_o), 0);
    check("midrst_data_o", longint'(data_o), 0);
    model_clear();
    @(negedge clk_i);
    rstn_i = 1'b1;
    @(negedge clk_i);
    shift_i = 6'd0;
    dir_q.push_back(8'h55);
    feed(16'h0055, 0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
